// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared state encoding and default widths for the ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    // Default operand/result and op-select widths of the shared ALU
    localparam int DATA_W_DEF = 8;
    localparam int SEL_W_DEF  = 3;

    // Largest supported requester count; grant indices are 3 bits wide
    localparam int MAX_N_REQ  = 8;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the request vector
//               starting one past the last winner, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       idx,
    output logic             any
);

    logic [3:0] cand;

    // Walk candidates last+1 .. last+N_REQ (mod N_REQ); first valid one wins
    always_comb begin
        any  = 1'b0;
        idx  = 3'd0;
        cand = 4'd0;
        gnt  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!any && req[j] && (cand == 4'(j))) begin
                    any = 1'b1;
                    idx = 3'(j);
                end
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            gnt[j] = any && (idx == 3'(j));
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one PrimitiveALU between N_REQ requesters. Requests are
//               accepted round-robin, issued to the ALU for two cycles, and the
//               captured result is returned over a per-requester response
//               handshake. One operation in flight, 4 cycles minimum each.
// Options     : ALU_ARBITER_STATS_EN adds a saturating 16-bit op_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*SEL_W-1:0]  req_sel,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic [N_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]       resp_out,
    output logic                    resp_flag,
    output logic                    alu_load,
    output logic [DATA_W-1:0]       alu_in_a,
    output logic [DATA_W-1:0]       alu_in_b,
    output logic [SEL_W-1:0]        alu_select,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_flag,
    output logic                    busy,
    output logic [2:0]              grant_id
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]             op_count
`endif
);

    arb_state_t        state_q, state_d;
    logic [2:0]        last_q,  last_d;
    logic [2:0]        grant_q, grant_d;
    logic [DATA_W-1:0] a_q,     a_d;
    logic [DATA_W-1:0] b_q,     b_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [DATA_W-1:0] res_q,   res_d;
    logic              flag_q,  flag_d;
    logic              resp_hs;

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0]       count_q, count_d;
`endif

    logic [N_REQ-1:0]  rr_gnt;
    logic [2:0]        rr_idx;
    logic              rr_any;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (rr_gnt),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    // Next-state, datapath latching and all handshake/ALU outputs
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        res_d      = res_q;
        flag_d     = flag_q;
        resp_hs    = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        alu_load   = 1'b0;
        alu_in_a   = '0;
        alu_in_b   = '0;
        alu_select = '0;
`ifdef ALU_ARBITER_STATS_EN
        count_d    = count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Grant is visible combinationally; payload captured on the edge
                if (rr_any) begin
                    req_ready = rr_gnt;
                    grant_d   = rr_idx;
                    state_d   = ST_ISSUE;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (rr_gnt[i]) begin
                            a_d   = req_a[i*DATA_W +: DATA_W];
                            b_d   = req_b[i*DATA_W +: DATA_W];
                            sel_d = req_sel[i*SEL_W +: SEL_W];
                        end
                    end
                end
            end

            ST_ISSUE: begin
                alu_load   = 1'b1;
                alu_in_a   = a_q;
                alu_in_b   = b_q;
                alu_select = sel_q;
                state_d    = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                // Operands held a second cycle so the ALU output is settled here
                alu_load   = 1'b1;
                alu_in_a   = a_q;
                alu_in_b   = b_q;
                alu_select = sel_q;
                res_d      = alu_out;
                flag_d     = alu_flag;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                // Only the granted requester's valid/ready pair participates
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_q == 3'(i)) begin
                        resp_valid[i] = 1'b1;
                        resp_hs       = resp_ready[i];
                    end
                end
                if (resp_hs) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
`ifdef ALU_ARBITER_STATS_EN
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 3'(N_REQ - 1);
            grant_q <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    // Completed-response counter, saturating at all ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign op_count = count_q;
`endif

    assign resp_out  = res_q;
    assign resp_flag = flag_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;

endmodule : alu_arbiter
`default_nettype wire
